osd_cmd_tx: RTL and testbench

Core-side transmitter for the OSD command bus (io_osd / io_strobe / io_din), the sending end of the OSD overlay's command receiver. It takes one command request at a time (disable, enable, enable-with-info-window, or 256-byte buffer block write) and serialises it into a framed, strobed word sequence on clk_sys. It is used where OSD content is produced inside the FPGA, for example test patterns and built-in status pages, without HPS involvement.

---
 rtl/osd_cmd_tx.sv | 232 +++++++++++++++++++++++
 tb/tb_osd_cmd_tx.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_cmd_tx.sv
// osd_cmd_tx: core-side transmitter for the OSD command bus.
// Accepts one command at a time and sends it as a framed, strobed word sequence.
module osd_cmd_tx #(
    parameter int STB_HI  = 2,
    parameter int STB_LO  = 2,
    parameter int GAP     = 4,
    parameter int BLK_LEN = 256
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_blk,
    input  logic [11:0] info_x,
    input  logic [11:0] info_y,
    input  logic [5:0]  info_w,
    input  logic [5:0]  info_h,
    input  logic [1:0]  info_rot,
    input  logic        dat_valid,
    output logic        dat_ready,
    input  logic [7:0]  dat_byte,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        busy,
    output logic        done
);

    localparam int MAX_HL = (STB_HI > STB_LO) ? STB_HI : STB_LO;
    localparam int MAX_PH = (MAX_HL > GAP) ? MAX_HL : GAP;
    localparam int PW     = $clog2(MAX_PH + 1);

    // Phase counters are loaded with (length - 1) and count down to zero.
    localparam logic [PW-1:0] PH_HI   = PW'(STB_HI - 1);
    localparam logic [PW-1:0] PH_LO   = PW'(STB_LO - 1);
    localparam logic [PW-1:0] PH_GAP  = PW'(GAP - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_ZERO = '0;

    // A write sends the header plus BLK_LEN data words, so BLK_LEN remain after it.
    localparam logic [8:0] BLK_WORDS = 9'(BLK_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_WAITD,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [8:0]      wcnt_q, wcnt_d;
    logic            is_wr_q, is_wr_d;
    logic [11:0]     info_x_q, info_x_d;
    logic [11:0]     info_y_q, info_y_d;
    logic [5:0]      info_w_q, info_w_d;
    logic [5:0]      info_h_q, info_h_d;
    logic [1:0]      info_rot_q, info_rot_d;
    logic            io_osd_q, io_osd_d;
    logic            io_strobe_q, io_strobe_d;
    logic [15:0]     io_din_q, io_din_d;
    logic            done_q, done_d;
    logic [15:0]     info_word;

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign dat_ready = (state_q == S_WAITD) && dat_valid;
    assign io_osd    = io_osd_q;
    assign io_strobe = io_strobe_q;
    assign io_din    = io_din_q;
    assign done      = done_q;

    // Select the next info-window operand from the count of words still to send.
    always_comb begin
        case (wcnt_q)
            9'd5:    info_word = {4'h0, info_x_q};
            9'd4:    info_word = {4'h0, info_y_q};
            9'd3:    info_word = {10'h000, info_w_q};
            9'd2:    info_word = {10'h000, info_h_q};
            default: info_word = {14'h0000, info_rot_q};
        endcase
    end

    // Next-state and next-output logic for the framing state machine.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        wcnt_d      = wcnt_q;
        is_wr_d     = is_wr_q;
        info_x_d    = info_x_q;
        info_y_d    = info_y_q;
        info_w_d    = info_w_q;
        info_h_d    = info_h_q;
        info_rot_d  = info_rot_q;
        io_osd_d    = io_osd_q;
        io_strobe_d = io_strobe_q;
        io_din_d    = io_din_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d     = S_OPEN;
                    io_osd_d    = 1'b1;
                    io_strobe_d = 1'b0;
                    is_wr_d     = (cmd_op == 2'd3);
                    info_x_d    = info_x;
                    info_y_d    = info_y;
                    info_w_d    = info_w;
                    info_h_d    = info_h;
                    info_rot_d  = info_rot;
                    case (cmd_op)
                        2'd0: begin
                            io_din_d = 16'h0040;
                            wcnt_d   = 9'd0;
                        end
                        2'd1: begin
                            io_din_d = 16'h0041;
                            wcnt_d   = 9'd0;
                        end
                        2'd2: begin
                            io_din_d = 16'h0045;
                            wcnt_d   = 9'd5;
                        end
                        default: begin
                            io_din_d = 16'h0020 | {11'h000, cmd_blk};
                            wcnt_d   = BLK_WORDS;
                        end
                    endcase
                end
            end

            S_OPEN: begin
                state_d = S_SETUP;
            end

            S_SETUP: begin
                state_d     = S_HIGH;
                phase_d     = PH_HI;
                io_strobe_d = 1'b1;
            end

            S_HIGH: begin
                if (phase_q == PH_ZERO) begin
                    state_d     = S_LOW;
                    phase_d     = PH_LO;
                    io_strobe_d = 1'b0;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end

            S_LOW: begin
                if (phase_q != PH_ZERO) begin
                    phase_d = phase_q - PH_ONE;
                end else if (wcnt_q == 9'd0) begin
                    state_d  = S_GAP;
                    phase_d  = PH_GAP;
                    io_osd_d = 1'b0;
                    io_din_d = 16'h0000;
                    done_d   = (PH_GAP == PH_ZERO);
                end else begin
                    wcnt_d = wcnt_q - 9'd1;
                    if (is_wr_q) begin
                        state_d = S_WAITD;
                    end else begin
                        state_d  = S_SETUP;
                        io_din_d = info_word;
                    end
                end
            end

            S_WAITD: begin
                if (dat_valid) begin
                    state_d  = S_SETUP;
                    io_din_d = {8'h00, dat_byte};
                end
            end

            S_GAP: begin
                if (phase_q == PH_ZERO) begin
                    state_d = S_IDLE;
                end else begin
                    phase_d = phase_q - PH_ONE;
                    done_d  = (phase_q == PH_ONE);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, latched command fields and bus outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            wcnt_q      <= 9'd0;
            is_wr_q     <= 1'b0;
            info_x_q    <= 12'h000;
            info_y_q    <= 12'h000;
            info_w_q    <= 6'h00;
            info_h_q    <= 6'h00;
            info_rot_q  <= 2'd0;
            io_osd_q    <= 1'b0;
            io_strobe_q <= 1'b0;
            io_din_q    <= 16'h0000;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            wcnt_q      <= wcnt_d;
            is_wr_q     <= is_wr_d;
            info_x_q    <= info_x_d;
            info_y_q    <= info_y_d;
            info_w_q    <= info_w_d;
            info_h_q    <= info_h_d;
            info_rot_q  <= info_rot_d;
            io_osd_q    <= io_osd_d;
            io_strobe_q <= io_strobe_d;
            io_din_q    <= io_din_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_osd_cmd_tx.sv
// tb_osd_cmd_tx: scoreboard bench for osd_cmd_tx.
// Instance a uses the default timing; instance b uses the shortest timing for back-to-back frames.
module tb_osd_cmd_tx;

    logic clk_sys = 1'b0;

    // Instance a stimulus and outputs.
    logic        rst_n_a, cmd_valid_a, dat_valid_a;
    logic [1:0]  cmd_op_a, info_rot_a;
    logic [4:0]  cmd_blk_a;
    logic [11:0] info_x_a, info_y_a;
    logic [5:0]  info_w_a, info_h_a;
    logic [7:0]  dat_byte_a;
    logic        cmd_ready_a, dat_ready_a, io_osd_a, io_strobe_a, busy_a, done_a;
    logic [15:0] io_din_a;

    // Instance b stimulus and outputs.
    logic        rst_n_b, cmd_valid_b, dat_valid_b;
    logic [1:0]  cmd_op_b, info_rot_b;
    logic [4:0]  cmd_blk_b;
    logic [11:0] info_x_b, info_y_b;
    logic [5:0]  info_w_b, info_h_b;
    logic [7:0]  dat_byte_b;
    logic        cmd_ready_b, dat_ready_b, io_osd_b, io_strobe_b, busy_b, done_b;
    logic [15:0] io_din_b;

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    int compared   = 0;
    int mismatched = 0;

    logic        mon_a_prev_stb = 1'b0;
    logic [15:0] mon_a_prev_din = 16'h0000;
    logic [15:0] mon_a_exp;
    logic        mon_b_prev_stb = 1'b0;
    logic [15:0] mon_b_prev_din = 16'h0000;
    logic [15:0] mon_b_exp;

    osd_cmd_tx dut_a (
        .clk_sys   (clk_sys),
        .reset_n   (rst_n_a),
        .cmd_valid (cmd_valid_a),
        .cmd_ready (cmd_ready_a),
        .cmd_op    (cmd_op_a),
        .cmd_blk   (cmd_blk_a),
        .info_x    (info_x_a),
        .info_y    (info_y_a),
        .info_w    (info_w_a),
        .info_h    (info_h_a),
        .info_rot  (info_rot_a),
        .dat_valid (dat_valid_a),
        .dat_ready (dat_ready_a),
        .dat_byte  (dat_byte_a),
        .io_osd    (io_osd_a),
        .io_strobe (io_strobe_a),
        .io_din    (io_din_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    osd_cmd_tx #(
        .STB_HI  (1),
        .STB_LO  (1),
        .GAP     (1),
        .BLK_LEN (256)
    ) dut_b (
        .clk_sys   (clk_sys),
        .reset_n   (rst_n_b),
        .cmd_valid (cmd_valid_b),
        .cmd_ready (cmd_ready_b),
        .cmd_op    (cmd_op_b),
        .cmd_blk   (cmd_blk_b),
        .info_x    (info_x_b),
        .info_y    (info_y_b),
        .info_w    (info_w_b),
        .info_h    (info_h_b),
        .info_rot  (info_rot_b),
        .dat_valid (dat_valid_b),
        .dat_ready (dat_ready_b),
        .dat_byte  (dat_byte_b),
        .io_osd    (io_osd_b),
        .io_strobe (io_strobe_b),
        .io_din    (io_din_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    // 100 MHz system clock.
    initial forever #5 clk_sys = ~clk_sys;

    // Hard time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got %0d compared, required completion", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor for instance a: every rising strobe pops one expected word.
    initial forever begin
        @(negedge clk_sys);
        if (io_strobe_a && !mon_a_prev_stb) begin
            checkOutput("a_osd_at_strobe", 32'(io_osd_a), 32'd1);
            checkOutput("a_din_stable_before_strobe", 32'(io_din_a), 32'(mon_a_prev_din));
            if (exp_a.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL a_word: got 0x%0h, expected no word", io_din_a);
            end else begin
                mon_a_exp = exp_a.pop_front();
                checkOutput("a_word", 32'(io_din_a), 32'(mon_a_exp));
            end
        end
        mon_a_prev_stb = io_strobe_a;
        mon_a_prev_din = io_din_a;
    end

    // Monitor for instance b.
    initial forever begin
        @(negedge clk_sys);
        if (io_strobe_b && !mon_b_prev_stb) begin
            checkOutput("b_osd_at_strobe", 32'(io_osd_b), 32'd1);
            checkOutput("b_din_stable_before_strobe", 32'(io_din_b), 32'(mon_b_prev_din));
            if (exp_b.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL b_word: got 0x%0h, expected no word", io_din_b);
            end else begin
                mon_b_exp = exp_b.pop_front();
                checkOutput("b_word", 32'(io_din_b), 32'(mon_b_exp));
            end
        end
        mon_b_prev_stb = io_strobe_b;
        mon_b_prev_din = io_din_b;
    end

    // Issue a non-write command to instance a and time the frame.
    task automatic applyStimulus(input logic [1:0] op, input logic [11:0] x, input logic [11:0] y,
                                 input logic [5:0] w, input logic [5:0] h, input logic [1:0] rot,
                                 input bit hold_valid, input int exp_cycles);
        int cyc, osd_hi, dn, drdy;
        case (op)
            2'd0: exp_a.push_back(16'h0040);
            2'd1: exp_a.push_back(16'h0041);
            default: begin
                exp_a.push_back(16'h0045);
                exp_a.push_back({4'h0, x});
                exp_a.push_back({4'h0, y});
                exp_a.push_back({10'h000, w});
                exp_a.push_back({10'h000, h});
                exp_a.push_back({14'h0000, rot});
            end
        endcase
        @(posedge clk_sys); #1;
        checkOutput("a_ready_before_cmd", 32'(cmd_ready_a), 32'd1);
        cmd_op_a = op; info_x_a = x; info_y_a = y; info_w_a = w; info_h_a = h; info_rot_a = rot;
        cmd_valid_a = 1'b1;
        dat_valid_a = 1'b1;
        dat_byte_a  = 8'hA5;
        @(posedge clk_sys); #1;
        cmd_op_a = ~op; info_x_a = ~x; info_y_a = ~y; info_w_a = ~w; info_h_a = ~h; info_rot_a = ~rot;
        cmd_valid_a = hold_valid;
        cyc = 0; osd_hi = int'(io_osd_a); dn = int'(done_a); drdy = int'(dat_ready_a);
        while (!cmd_ready_a && cyc < 5000) begin
            if (done_a) cmd_valid_a = 1'b0;
            @(posedge clk_sys); #1;
            cyc++;
            osd_hi += int'(io_osd_a);
            dn     += int'(done_a);
            drdy   += int'(dat_ready_a);
        end
        cmd_valid_a = 1'b0;
        dat_valid_a = 1'b0;
        checkOutput("a_frame_cycles", 32'(cyc), 32'(exp_cycles));
        checkOutput("a_osd_high_cycles", 32'(osd_hi), 32'(exp_cycles - 4));
        checkOutput("a_done_pulses", 32'(dn), 32'd1);
        checkOutput("a_stray_dat_ready", 32'(drdy), 32'd0);
    endtask

    // Issue a block write to instance a, feeding bytes 0..255 with an optional stall.
    task automatic sendBlock(input logic [4:0] blk, input int stall_at, input int stall_len, input int exp_cycles);
        int idx, pulses, cyc, bad, osd_lo;
        bit stalled, fin;
        exp_a.push_back(16'h0020 | {11'h000, blk});
        for (int i = 0; i < 256; i++) exp_a.push_back({8'h00, 8'(i)});
        @(posedge clk_sys); #1;
        cmd_op_a = 2'd3; cmd_blk_a = blk; cmd_valid_a = 1'b1;
        dat_valid_a = 1'b1; dat_byte_a = 8'h00;
        @(posedge clk_sys); #1;
        cmd_valid_a = 1'b0; cmd_blk_a = ~blk; cmd_op_a = 2'd0;
        idx = 0; pulses = 0; cyc = 0; bad = 0; osd_lo = 0; stalled = 1'b0; fin = 1'b0;
        while (!fin && cyc < 5000) begin
            @(negedge clk_sys);
            if (dat_ready_a) begin
                idx++;
                pulses++;
            end
            if (!io_osd_a) osd_lo++;
            if (done_a) fin = 1'b1;
            if (!fin) begin
                @(posedge clk_sys); #1;
                cyc++;
                dat_byte_a = 8'(idx);
                if (stall_len > 0 && !stalled && idx == stall_at) begin
                    stalled = 1'b1;
                    dat_valid_a = 1'b0;
                    for (int s = 0; s < stall_len; s++) begin
                        @(negedge clk_sys);
                        if (dat_ready_a) pulses++;
                        if (s >= 10 && (!io_osd_a || io_strobe_a)) bad++;
                        @(posedge clk_sys); #1;
                        cyc++;
                    end
                    dat_valid_a = 1'b1;
                end
            end
        end
        checkOutput("a_blk_dat_ready_pulses", 32'(pulses), 32'd256);
        checkOutput("a_blk_osd_low_cycles", 32'(osd_lo), 32'd4);
        if (stall_len > 0) checkOutput("a_blk_stall_violations", 32'(bad), 32'd0);
        if (exp_cycles > 0) checkOutput("a_blk_frame_cycles", 32'(cyc + 1), 32'(exp_cycles));
        @(posedge clk_sys); #1;
        checkOutput("a_blk_ready_after", 32'(cmd_ready_a), 32'd1);
        dat_valid_a = 1'b0;
    endtask

    // Pull reset during the HIGH phase of the third word of an info command.
    task automatic resetMidFrame();
        int rises, cyc;
        logic prev;
        exp_a.push_back(16'h0045);
        exp_a.push_back(16'h0111);
        exp_a.push_back(16'h0222);
        exp_a.push_back(16'h0033);
        exp_a.push_back(16'h0004);
        exp_a.push_back(16'h0002);
        @(posedge clk_sys); #1;
        cmd_op_a = 2'd2; info_x_a = 12'h111; info_y_a = 12'h222;
        info_w_a = 6'h33; info_h_a = 6'h04; info_rot_a = 2'd2;
        cmd_valid_a = 1'b1;
        @(posedge clk_sys); #1;
        cmd_valid_a = 1'b0;
        rises = 0; cyc = 0; prev = io_strobe_a;
        while (rises < 3 && cyc < 500) begin
            @(posedge clk_sys); #1;
            cyc++;
            if (io_strobe_a && !prev) rises++;
            prev = io_strobe_a;
        end
        @(posedge clk_sys); #2;
        checkOutput("a_strobe_before_reset", 32'(io_strobe_a), 32'd1);
        rst_n_a = 1'b0;
        #1;
        checkOutput("a_reset_async_outputs",
                    32'({io_osd_a, io_strobe_a, io_din_a, busy_a, done_a, dat_ready_a}), 32'd0);
        exp_a.delete();
        repeat (3) @(posedge clk_sys);
        #1;
        rst_n_a = 1'b1;
        @(posedge clk_sys); #1;
        checkOutput("a_ready_after_midframe_reset", 32'(cmd_ready_a), 32'd1);
    endtask

    // Hold cmd_valid on instance b and check the back-to-back frame rhythm.
    task automatic backToBack();
        int acc, low_runs, bad_runs, bad_misc, strobe_low, run_len;
        logic run_val, seen_high, prev_done;
        acc = 0; low_runs = 0; bad_runs = 0; bad_misc = 0; strobe_low = 0;
        cmd_op_b = 2'd1;
        @(negedge clk_sys);
        run_val = io_osd_b; run_len = 0; seen_high = 1'b0; prev_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk_sys);
            if (io_strobe_b && !io_osd_b) strobe_low++;
            if (busy_b == cmd_ready_b) bad_misc++;
            if (prev_done && !cmd_ready_b) bad_misc++;
            if (dat_ready_b) bad_misc++;
            prev_done = done_b;
            if (io_osd_b == run_val) begin
                run_len++;
            end else begin
                if (run_val && run_len != 4) bad_runs++;
                if (!run_val && seen_high) begin
                    low_runs++;
                    if (run_len != 2) bad_runs++;
                end
                if (run_val) seen_high = 1'b1;
                run_val = io_osd_b;
                run_len = 1;
            end
            if (c == 59) begin
                cmd_valid_b = 1'b0;
            end else begin
                cmd_valid_b = 1'b1;
                if (cmd_ready_b) begin
                    exp_b.push_back(16'h0041);
                    acc++;
                end
            end
        end
        repeat (10) @(posedge clk_sys);
        #1;
        checkOutput("b_strobe_while_osd_low", 32'(strobe_low), 32'd0);
        checkOutput("b_run_length_errors", 32'(bad_runs), 32'd0);
        checkOutput("b_handshake_errors", 32'(bad_misc), 32'd0);
        checkOutput("b_enough_frames", 32'(low_runs >= 5 && acc >= 6), 32'd1);
    endtask

    // Main sequence.
    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        cmd_valid_a = 1'b0; cmd_op_a = 2'd0; cmd_blk_a = 5'd0;
        info_x_a = 12'h000; info_y_a = 12'h000; info_w_a = 6'h00; info_h_a = 6'h00; info_rot_a = 2'd0;
        dat_valid_a = 1'b1; dat_byte_a = 8'h00;
        cmd_valid_b = 1'b0; cmd_op_b = 2'd0; cmd_blk_b = 5'd0;
        info_x_b = 12'h000; info_y_b = 12'h000; info_w_b = 6'h00; info_h_b = 6'h00; info_rot_b = 2'd0;
        dat_valid_b = 1'b1; dat_byte_b = 8'h00;

        repeat (2) @(posedge clk_sys);
        #1;
        checkOutput("a_reset_values",
                    32'({io_osd_a, io_strobe_a, io_din_a, dat_ready_a, busy_a, done_a}), 32'd0);
        dat_valid_a = 1'b0;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        @(posedge clk_sys); #1;
        checkOutput("a_ready_after_reset_release", 32'(cmd_ready_a), 32'd1);

        $display("[TB] op0 disable");
        applyStimulus(2'd0, 12'h000, 12'h000, 6'h00, 6'h00, 2'd0, 1'b0, 10);
        $display("[TB] op2 info window, cmd_valid held during frame");
        applyStimulus(2'd2, 12'h123, 12'h045, 6'h20, 6'h08, 2'd1, 1'b1, 35);
        $display("[TB] op2 info window, full-scale operands");
        applyStimulus(2'd2, 12'hFFF, 12'hABC, 6'h3F, 6'h01, 2'd3, 1'b0, 35);
        $display("[TB] op3 block 9, data always valid");
        sendBlock(5'd9, 0, 0, 1546);
        $display("[TB] op3 block 31, 50-cycle stall at byte 100");
        sendBlock(5'd31, 100, 50, 0);
        $display("[TB] reset during word 3");
        resetMidFrame();
        $display("[TB] op1 enable after reset");
        applyStimulus(2'd1, 12'h000, 12'h000, 6'h00, 6'h00, 2'd0, 1'b0, 10);
        $display("[TB] back-to-back frames on minimum timing");
        backToBack();

        repeat (20) @(posedge clk_sys);
        #1;
        checkOutput("a_queue_drained", 32'(exp_a.size()), 32'd0);
        checkOutput("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
